imem_burst_responder: RTL and testbench

//  Memory-side responder for the instruction-fetch burst interface. Accepts a

---
 rtl/imem_burst_responder.sv | 147 ++++++++++++++
 tb/tb_imem_burst_responder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_burst_responder.sv
`default_nettype none
// ============================================================================
// Module   : imem_burst_responder
// Purpose  : I-fetch line-fill responder; returns BURST_LEN words from a
//            loadable word store after a fixed access latency.
// Revision : 1.0 - initial release
// ============================================================================
module imem_burst_responder #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 22,
  parameter int DEPTH_WIDTH   = 10,
  parameter int BURST_LEN     = 4,
  parameter int LATENCY       = 2
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_MEM_Valid,
  input  logic [ADDRESS_WIDTH-1:0] i_MEM_Address,
  output logic                     o_MEM_Valid,
  output logic                     o_MEM_Last,
  output logic [DATA_WIDTH-1:0]    o_MEM_Data,
  input  logic                     i_Load_Valid,
  input  logic [DEPTH_WIDTH-1:0]   i_Load_Address,
  input  logic [DATA_WIDTH-1:0]    i_Load_Data,
  output logic                     o_Busy
);

  localparam int                  c_BEAT_W    = $clog2(BURST_LEN);
  localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(BURST_LEN - 1);
  localparam logic [3:0]          c_LATENCY   = 4'(LATENCY);
  localparam logic                c_ZERO_LAT  = (LATENCY == 0);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_WAIT  = 2'd1;
  localparam logic [1:0] c_ST_BURST = 2'd2;
  localparam logic [1:0] c_ST_DONE  = 2'd3;

  logic [1:0]             r_state;
  logic [1:0]             w_next_state;
  logic [DEPTH_WIDTH-1:0] r_base;
  logic [DEPTH_WIDTH-1:0] w_rd_addr;
  logic [c_BEAT_W-1:0]    r_beat;
  logic [3:0]             r_lat;
  logic                   w_accept;
  logic                   w_beat_fire;
  logic                   w_beat_last;
  logic                   r_mem_valid;
  logic                   r_mem_last;
  logic [DATA_WIDTH-1:0]  r_mem_data;
  logic                   r_busy;
  logic [DATA_WIDTH-1:0]  r_store [2**DEPTH_WIDTH];
  logic                   w_unused_addr;

  // Only the in-store word bits above the beat offset select a line.
  assign w_unused_addr = ^{i_MEM_Address[ADDRESS_WIDTH-1:DEPTH_WIDTH+1],
                           i_MEM_Address[c_BEAT_W:0]};

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (i_MEM_Valid) begin
          w_next_state = c_ZERO_LAT ? c_ST_BURST : c_ST_WAIT;
        end
      end
      c_ST_WAIT: begin
        if (!i_MEM_Valid) begin
          w_next_state = c_ST_IDLE;
        end else if (r_lat <= 4'd1) begin
          w_next_state = c_ST_BURST;
        end
      end
      c_ST_BURST: begin
        if (!i_MEM_Valid) begin
          w_next_state = c_ST_IDLE;
        end else if (r_beat == c_LAST_BEAT) begin
          w_next_state = c_ST_DONE;
        end
      end
      c_ST_DONE: w_next_state = c_ST_IDLE;
      default:   w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_accept    = 1'b0;
    w_beat_fire = 1'b0;
    w_beat_last = 1'b0;
    w_rd_addr   = r_base + DEPTH_WIDTH'(r_beat);
    if (r_state == c_ST_IDLE) begin
      w_accept = i_MEM_Valid;
    end
    // A dropped request in BURST suppresses the beat registered at this edge.
    if (r_state == c_ST_BURST) begin
      w_beat_fire = i_MEM_Valid;
      w_beat_last = i_MEM_Valid && (r_beat == c_LAST_BEAT);
    end
  end

  always_ff @(posedge i_Clk or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_base      <= '0;
      r_beat      <= '0;
      r_lat       <= 4'd0;
      r_mem_valid <= 1'b0;
      r_mem_last  <= 1'b0;
      r_mem_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_base <= {i_MEM_Address[DEPTH_WIDTH:c_BEAT_W+1], {c_BEAT_W{1'b0}}};
        r_beat <= '0;
        r_lat  <= c_LATENCY;
      end else if (r_state == c_ST_WAIT) begin
        r_lat <= r_lat - 4'd1;
      end else if (w_beat_fire) begin
        r_beat <= r_beat + c_BEAT_W'(1);
      end
      r_mem_valid <= w_beat_fire;
      r_mem_last  <= w_beat_last;
      r_mem_data  <= w_beat_fire ? r_store[w_rd_addr] : '0;
      r_busy      <= (r_state != c_ST_IDLE);
    end
  end

  // Store is not reset; a same-edge load lands after this edge's beat read.
  always_ff @(posedge i_Clk) begin
    if (i_Load_Valid) begin
      r_store[i_Load_Address] <= i_Load_Data;
    end
  end

  assign o_MEM_Valid = r_mem_valid;
  assign o_MEM_Last  = r_mem_last;
  assign o_MEM_Data  = r_mem_data;
  assign o_Busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_imem_burst_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_burst_responder
// Purpose  : Self-checking bench for imem_burst_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_burst_responder;

  localparam int DW    = 32;
  localparam int AW    = 22;
  localparam int DPW   = 10;
  localparam int BL    = 4;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << DPW;

  logic           i_Clk          = 1'b0;
  logic           i_Reset_n      = 1'b0;
  logic           i_MEM_Valid    = 1'b0;
  logic [AW-1:0]  i_MEM_Address  = '0;
  logic           o_MEM_Valid;
  logic           o_MEM_Last;
  logic [DW-1:0]  o_MEM_Data;
  logic           i_Load_Valid   = 1'b0;
  logic [DPW-1:0] i_Load_Address = '0;
  logic [DW-1:0]  i_Load_Data    = '0;
  logic           o_Busy;

  logic [DW-1:0]  model_mem [DEPTH];
  int             checks   = 0;
  int             failures = 0;

  imem_burst_responder #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .DEPTH_WIDTH(DPW),
    .BURST_LEN(BL), .LATENCY(LAT)
  ) dut (
    .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
    .i_MEM_Valid(i_MEM_Valid), .i_MEM_Address(i_MEM_Address),
    .o_MEM_Valid(o_MEM_Valid), .o_MEM_Last(o_MEM_Last), .o_MEM_Data(o_MEM_Data),
    .i_Load_Valid(i_Load_Valid), .i_Load_Address(i_Load_Address),
    .i_Load_Data(i_Load_Data), .o_Busy(o_Busy)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic load_word(input int addr, input logic [DW-1:0] data);
    i_Load_Valid   = 1'b1;
    i_Load_Address = DPW'(addr);
    i_Load_Data    = data;
    model_mem[addr % DEPTH] = data;
    @(negedge i_Clk);
    i_Load_Valid = 1'b0;
  endtask

  // Request issued before edge 0; cycle n is observed after edge n.
  task automatic drive_and_check(input string tag, input int word, input bit keep,
                                 input int load_cyc, input int load_addr,
                                 input logic [DW-1:0] load_data);
    int            base;
    int            k;
    logic          exp_v, exp_l, exp_b;
    logic [DW-1:0] exp_d;
    base = (word % DEPTH) & ~(BL - 1);
    i_MEM_Valid   = 1'b1;
    i_MEM_Address = AW'(word * 2) | AW'($urandom_range(0, 1));
    for (int cyc = 0; cyc <= LAT + BL + 1; cyc++) begin
      if (cyc == load_cyc) begin
        i_Load_Valid   = 1'b1;
        i_Load_Address = DPW'(load_addr);
        i_Load_Data    = load_data;
      end
      @(posedge i_Clk);
      @(negedge i_Clk);
      i_Load_Valid = 1'b0;
      k     = cyc - LAT - 1;
      exp_v = (k >= 0) && (k < BL);
      exp_l = (k == BL - 1);
      exp_d = exp_v ? model_mem[(base + k) % DEPTH] : '0;
      exp_b = (cyc >= 1);
      checks++;
      if (o_MEM_Valid !== exp_v) begin
        failures++;
        $display("FAIL %s valid cyc=%0d got=%b exp=%b", tag, cyc, o_MEM_Valid, exp_v);
      end
      checks++;
      if (o_MEM_Last !== exp_l) begin
        failures++;
        $display("FAIL %s last cyc=%0d got=%b exp=%b", tag, cyc, o_MEM_Last, exp_l);
      end
      checks++;
      if (o_MEM_Data !== exp_d) begin
        failures++;
        $display("FAIL %s data cyc=%0d got=%h exp=%h", tag, cyc, o_MEM_Data, exp_d);
      end
      checks++;
      if (o_Busy !== exp_b) begin
        failures++;
        $display("FAIL %s busy cyc=%0d got=%b exp=%b", tag, cyc, o_Busy, exp_b);
      end
      if (cyc == load_cyc) model_mem[load_addr % DEPTH] = load_data;
      if (cyc >= 1 && cyc <= LAT + BL) i_MEM_Address = AW'($urandom);
      if (cyc == LAT + BL && !keep) i_MEM_Valid = 1'b0;
    end
  endtask

  task automatic abort_at(input string tag, input int word, input int drop_cyc);
    int            base;
    int            k;
    logic          exp_v;
    logic [DW-1:0] exp_d;
    base = (word % DEPTH) & ~(BL - 1);
    i_MEM_Valid   = 1'b1;
    i_MEM_Address = AW'(word * 2);
    for (int cyc = 0; cyc <= drop_cyc + 3; cyc++) begin
      @(posedge i_Clk);
      @(negedge i_Clk);
      k     = cyc - LAT - 1;
      exp_v = (cyc <= drop_cyc) && (k >= 0) && (k < BL);
      exp_d = exp_v ? model_mem[(base + k) % DEPTH] : '0;
      checks++;
      if (o_MEM_Valid !== exp_v || o_MEM_Data !== exp_d) begin
        failures++;
        $display("FAIL %s beat cyc=%0d got=%b/%h exp=%b/%h", tag, cyc,
                 o_MEM_Valid, o_MEM_Data, exp_v, exp_d);
      end
      checks++;
      if (o_MEM_Last !== 1'b0) begin
        failures++;
        $display("FAIL %s last cyc=%0d got=%b exp=0", tag, cyc, o_MEM_Last);
      end
      if (cyc == drop_cyc + 1) begin
        checks++;
        if (o_Busy !== 1'b1) begin
          failures++;
          $display("FAIL %s busy cyc=%0d got=%b exp=1", tag, cyc, o_Busy);
        end
      end
      if (cyc == drop_cyc + 2) begin
        checks++;
        if (o_Busy !== 1'b0) begin
          failures++;
          $display("FAIL %s busy cyc=%0d got=%b exp=0", tag, cyc, o_Busy);
        end
      end
      if (cyc == drop_cyc) i_MEM_Valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge i_Clk);
    checks++;
    if ({o_MEM_Valid, o_MEM_Last, o_MEM_Data, o_Busy} !== '0) begin
      failures++;
      $display("FAIL reset_hold got v=%b l=%b d=%h b=%b exp all 0",
               o_MEM_Valid, o_MEM_Last, o_MEM_Data, o_Busy);
    end
    i_Reset_n = 1'b1;
    repeat (2) @(negedge i_Clk);
    checks++;
    if ({o_MEM_Valid, o_MEM_Last, o_MEM_Data, o_Busy} !== '0) begin
      failures++;
      $display("FAIL reset_idle got v=%b l=%b d=%h b=%b exp all 0",
               o_MEM_Valid, o_MEM_Last, o_MEM_Data, o_Busy);
    end
  endtask

  task automatic load_all;
    for (int i = 0; i < DEPTH; i++) begin
      i_Load_Valid   = 1'b1;
      i_Load_Address = DPW'(i);
      i_Load_Data    = $urandom;
      model_mem[i]   = i_Load_Data;
      @(negedge i_Clk);
    end
    i_Load_Valid = 1'b0;
  endtask

  task automatic test_basic;
    for (int i = 0; i < 8; i++) load_word(32'h100 + i, DW'(32'hA0 + i));
    drive_and_check("basic", 32'h104, 1'b0, -1, 0, '0);
    drive_and_check("unaligned", 32'h106, 1'b0, -1, 0, '0);
  endtask

  task automatic test_wrap;
    drive_and_check("wrap_top", DEPTH - 4, 1'b0, -1, 0, '0);
    drive_and_check("wrap_top_unal", DEPTH - 1, 1'b0, -1, 0, '0);
    drive_and_check("wrap_alias0", DEPTH, 1'b0, -1, 0, '0);
    drive_and_check("wrap_alias_hi", (7 << DPW) + 5, 1'b0, -1, 0, '0);
  endtask

  task automatic test_abort;
    abort_at("abort_beat1", 32'h104, LAT + 2);
    abort_at("abort_wait", 32'h104, 1);
    abort_at("abort_prelast", 32'h100, LAT + BL - 1);
    drive_and_check("after_abort", 32'h104, 1'b0, -1, 0, '0);
  endtask

  task automatic test_back_to_back;
    drive_and_check("b2b_first", 32'h100, 1'b1, -1, 0, '0);
    drive_and_check("b2b_second", 32'h104, 1'b0, -1, 0, '0);
  endtask

  task automatic test_load_collision;
    drive_and_check("collide_same_edge", 32'h104, 1'b0, LAT + 2, 32'h105, 32'hBEEF);
    drive_and_check("collide_repeat", 32'h104, 1'b0, -1, 0, '0);
  endtask

  task automatic test_async_reset(input string tag, input int word, input int stop_cyc);
    i_MEM_Valid   = 1'b1;
    i_MEM_Address = AW'(word * 2);
    for (int cyc = 0; cyc <= stop_cyc; cyc++) begin
      @(posedge i_Clk);
      @(negedge i_Clk);
    end
    checks++;
    if (o_Busy !== 1'b1) begin
      failures++;
      $display("FAIL %s pre_busy got=%b exp=1", tag, o_Busy);
    end
    #2 i_Reset_n = 1'b0;
    #1;
    checks++;
    if ({o_MEM_Valid, o_MEM_Last, o_MEM_Data, o_Busy} !== '0) begin
      failures++;
      $display("FAIL %s async_drop got v=%b l=%b d=%h b=%b exp all 0", tag,
               o_MEM_Valid, o_MEM_Last, o_MEM_Data, o_Busy);
    end
    i_MEM_Valid = 1'b0;
    @(negedge i_Clk);
    i_Reset_n = 1'b1;
    @(negedge i_Clk);
    drive_and_check({tag, "_after"}, word, 1'b0, -1, 0, '0);
  endtask

  task automatic test_random;
    int word, la;
    for (int n = 0; n < 10; n++) begin
      word = int'($urandom_range(0, (1 << (AW - 1)) - 1));
      la   = (((word % DEPTH) & ~(BL - 1)) + int'($urandom_range(0, BL - 1))) % DEPTH;
      drive_and_check("random", word, 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, LAT + BL)), la, DW'($urandom));
    end
    i_MEM_Valid = 1'b0;
    repeat (2) @(negedge i_Clk);
  endtask

  initial begin
    test_reset();
    load_all();
    test_basic();
    test_wrap();
    test_abort();
    test_back_to_back();
    test_load_collision();
    test_async_reset("rst_wait", 32'h104, 1);
    test_async_reset("rst_burst", 32'h100, LAT + 2);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
